// File: rtl/mem_lsu_rmw_pkg.sv
// -----------------------------------------------------------------------------
// mem_lsu_pkg : shared definitions for the mem_lsu_rmw load/store unit.
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD, plus the reserved code)
//   - FSM state encodings
//   - lane_sel      : first byte lane touched by an access
//   - is_misaligned : legality check for a size / low-address pair
// No ports (package).
// -----------------------------------------------------------------------------
package mem_lsu_pkg;

    localparam int LSU_ADDR_W = 32;
    localparam int LSU_DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LD_WAIT = 2'd1,
        ST_RMW     = 2'd2
    } state_e;

    // Little-endian lane of the lowest byte touched. Address bits below the
    // access size are dropped, so a halfword always starts on lane 0 or 2.
    function automatic logic [1:0] lane_sel(input size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: return lo;
            SZ_HALF: return {lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    // Reserved size is never legal.
    function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            SZ_WORD: return |lo;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_rmw_if.sv
// -----------------------------------------------------------------------------
// mem_lsu_rmw_if : request/response bundle around the load/store unit.
//   Pipeline side : in_valid, in_rd_req, in_wr_req, in_size, in_ld_unsigned,
//                   in_addr, in_st_data, in_rd_idx -> LSU ; out_stall <- LSU
//   MEM_core side : out_MemWr, out_MemRd, out_Wr_data, out_WrRd_addr <- LSU ;
//                   in_Rd_data -> LSU
//   WB side       : out_ld_valid, out_ld_data, out_ld_rd_idx, out_misalign <- LSU
// Modports: slave (the LSU), master (everything around it).
// -----------------------------------------------------------------------------
interface mem_lsu_rmw_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_rd_req;
    logic              in_wr_req;
    logic [1:0]        in_size;
    logic              in_ld_unsigned;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_st_data;
    logic [4:0]        in_rd_idx;
    logic              out_stall;
    logic              out_MemWr;
    logic              out_MemRd;
    logic [DATA_W-1:0] out_Wr_data;
    logic [ADDR_W-1:0] out_WrRd_addr;
    logic [DATA_W-1:0] in_Rd_data;
    logic              out_ld_valid;
    logic [DATA_W-1:0] out_ld_data;
    logic [4:0]        out_ld_rd_idx;
    logic              out_misalign;

    modport slave (
        input  in_valid, in_rd_req, in_wr_req, in_size, in_ld_unsigned,
               in_addr, in_st_data, in_rd_idx, in_Rd_data,
        output out_stall, out_MemWr, out_MemRd, out_Wr_data, out_WrRd_addr,
               out_ld_valid, out_ld_data, out_ld_rd_idx, out_misalign
    );

    modport master (
        output in_valid, in_rd_req, in_wr_req, in_size, in_ld_unsigned,
               in_addr, in_st_data, in_rd_idx, in_Rd_data,
        input  out_stall, out_MemWr, out_MemRd, out_Wr_data, out_WrRd_addr,
               out_ld_valid, out_ld_data, out_ld_rd_idx, out_misalign
    );
endinterface

// File: rtl/mem_lsu_rmw_lane.sv
// -----------------------------------------------------------------------------
// mem_lsu_lane : combinational byte-lane datapath shared by the load and the
// read-modify-write paths.
//   i_size, i_lane : latched access size and first byte lane
//   i_unsigned     : zero-extend instead of sign-extend
//   i_rd_word      : word returned by MEM_core
//   i_st_data      : store data, sub-word value in the low bits
//   o_ld_ext       : extracted and extended load value
//   o_merged       : i_rd_word with the store bytes replaced at i_lane
// -----------------------------------------------------------------------------
module mem_lsu_lane
    import mem_lsu_pkg::*;
(
    input  size_e       i_size,
    input  logic [1:0]  i_lane,
    input  logic        i_unsigned,
    input  logic [31:0] i_rd_word,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_ld_ext,
    output logic [31:0] o_merged
);
    logic [31:0] w_shifted;
    logic [31:0] w_ins;
    logic [3:0]  w_byte_en;

    // Load: bring the addressed lane down to bit 0.
    assign w_shifted = i_rd_word >> {i_lane, 3'b000};
    // Store: move the sub-word up to its lane.
    assign w_ins     = i_st_data << {i_lane, 3'b000};

    always_comb begin
        o_ld_ext = i_rd_word;
        case (i_size)
            SZ_BYTE: o_ld_ext = {{24{~i_unsigned & w_shifted[7]}},  w_shifted[7:0]};
            SZ_HALF: o_ld_ext = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default: o_ld_ext = i_rd_word;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_byte_en[gi] = (i_size == SZ_BYTE) ? (i_lane == 2'(gi)) :
                                   (i_size == SZ_HALF) ? (i_lane[1] == 1'(gi / 2)) :
                                   1'b1;
            assign o_merged[8*gi +: 8] = w_byte_en[gi] ? w_ins[8*gi +: 8]
                                                       : i_rd_word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_lsu_rmw.sv
// -----------------------------------------------------------------------------
// mem_lsu_rmw : load/store unit between EX/MEM and MEM_core.
//   in_clk   : clock, rising edge
//   in_rst_n : asynchronous active-low reset
//   bus      : mem_lsu_rmw_if.slave (pipeline request, MEM_core access,
//              WB load result, misalignment pulse)
// Aligned SW is written in the accept cycle. Loads read in the accept cycle and
// return a registered, extended result two cycles later. SB/SH read the word,
// then write the merged word one cycle later (read-modify-write).
// Build option LSU_MISALIGN_TRAP_EN: when defined, illegal requests make no
// access and pulse out_misalign; when undefined, low address bits below the
// access size are ignored and size 3 is treated as a word.
// -----------------------------------------------------------------------------
module mem_lsu_rmw
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int DATA_W = LSU_DATA_W
) (
    input  logic          in_clk,
    input  logic          in_rst_n,
    mem_lsu_rmw_if.slave  bus
);
    state_e            r_state;
    size_e             r_size;
    logic [1:0]        r_lane;
    logic              r_unsigned;
    logic [4:0]        r_rd_idx;
    logic [DATA_W-1:0] r_st_data;
    logic [ADDR_W-1:0] r_addr;
    logic              r_ld_valid;
    logic [DATA_W-1:0] r_ld_data;
    logic [4:0]        r_ld_rd_idx;
    logic              r_misalign;

    logic              w_is_store;
    logic              w_is_load;
    logic              w_accept;
    logic              w_illegal;
    logic              w_go;
    size_e             w_req_size;
    logic [1:0]        w_req_lane;
    logic [ADDR_W-1:0] w_req_addr;
    logic [31:0]       w_ld_ext;
    logic [31:0]       w_merged;
    logic              w_stall;
    logic              w_mem_wr;
    logic              w_mem_rd;
    logic [DATA_W-1:0] w_wr_data;
    logic [ADDR_W-1:0] w_addr;

    // Both request bits set means store.
    assign w_is_store = bus.in_wr_req;
    assign w_is_load  = bus.in_rd_req & ~bus.in_wr_req;
    assign w_accept   = (r_state == ST_IDLE) & bus.in_valid & (w_is_store | w_is_load);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_req_size = size_e'(bus.in_size);
    assign w_illegal  = is_misaligned(size_e'(bus.in_size), bus.in_addr[1:0]);
`else
    assign w_req_size = (size_e'(bus.in_size) == SZ_RSVD) ? SZ_WORD : size_e'(bus.in_size);
    assign w_illegal  = 1'b0;
`endif

    assign w_go       = w_accept & ~w_illegal;
    assign w_req_lane = lane_sel(w_req_size, bus.in_addr[1:0]);
    assign w_req_addr = {bus.in_addr[ADDR_W-1:2], 2'b00};

    mem_lsu_lane u_lane (
        .i_size     (r_size),
        .i_lane     (r_lane),
        .i_unsigned (r_unsigned),
        .i_rd_word  (bus.in_Rd_data),
        .i_st_data  (r_st_data),
        .o_ld_ext   (w_ld_ext),
        .o_merged   (w_merged)
    );

    // MEM_core controls are combinational so SW and the first read of a
    // multi-cycle op happen in the accept cycle. Reset forces them quiet so an
    // RMW caught by reset never reaches memory.
    always_comb begin
        w_stall   = 1'b0;
        w_mem_wr  = 1'b0;
        w_mem_rd  = 1'b0;
        w_wr_data = '0;
        w_addr    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_addr = w_req_addr;
                    if (w_is_store && (w_req_size == SZ_WORD)) begin
                        w_mem_wr  = 1'b1;
                        w_wr_data = bus.in_st_data;
                    end else begin
                        w_mem_rd  = 1'b1;
                    end
                end
            end
            ST_LD_WAIT: w_stall = 1'b1;
            ST_RMW: begin
                w_stall   = 1'b1;
                w_mem_wr  = 1'b1;
                w_wr_data = w_merged;
                w_addr    = r_addr;
            end
            default: ;
        endcase
        if (!in_rst_n) begin
            w_stall   = 1'b0;
            w_mem_wr  = 1'b0;
            w_mem_rd  = 1'b0;
            w_wr_data = '0;
            w_addr    = '0;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state     <= ST_IDLE;
            r_size      <= SZ_BYTE;
            r_lane      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_rd_idx    <= '0;
            r_st_data   <= '0;
            r_addr      <= '0;
            r_ld_valid  <= 1'b0;
            r_ld_data   <= '0;
            r_ld_rd_idx <= '0;
            r_misalign  <= 1'b0;
        end else begin
            r_ld_valid <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_illegal) begin
                            r_misalign <= 1'b1;
                        end else if (w_is_load || (w_req_size != SZ_WORD)) begin
                            r_size     <= w_req_size;
                            r_lane     <= w_req_lane;
                            r_unsigned <= bus.in_ld_unsigned;
                            r_rd_idx   <= bus.in_rd_idx;
                            r_st_data  <= bus.in_st_data;
                            r_addr     <= w_req_addr;
                            r_state    <= w_is_load ? ST_LD_WAIT : ST_RMW;
                        end
                    end
                end
                ST_LD_WAIT: begin
                    r_ld_data   <= w_ld_ext;
                    r_ld_rd_idx <= r_rd_idx;
                    r_ld_valid  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                ST_RMW:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_stall     = w_stall;
    assign bus.out_MemWr     = w_mem_wr;
    assign bus.out_MemRd     = w_mem_rd;
    assign bus.out_Wr_data   = w_wr_data;
    assign bus.out_WrRd_addr = w_addr;
    assign bus.out_ld_valid  = r_ld_valid;
    assign bus.out_ld_data   = r_ld_data;
    assign bus.out_ld_rd_idx = r_ld_rd_idx;
    assign bus.out_misalign  = r_misalign;

endmodule

// File: tb/tb_mem_lsu_rmw.sv
// -----------------------------------------------------------------------------
// tb_mem_lsu_rmw : bench for mem_lsu_rmw. Plays the pipeline and MEM_core
// (synchronous-read word memory), keeps a byte-level reference memory, and
// compares every cycle's outputs against expectations derived from it.
// -----------------------------------------------------------------------------
module tb_mem_lsu_rmw;

    logic clk;
    logic rst_n;

    mem_lsu_rmw_if bus ();

    mem_lsu_rmw dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc_no = 0;
    int          n_txn = 0;
    int          ld_due = -100;
    int          mis_due = -100;
    logic [31:0] exp_ld_data = 0;
    logic [4:0]  exp_ld_idx = 0;
    logic [31:0] last_ld;
    logic [31:0] last_wd;
    logic [31:0] rd_next = 0;
    logic [31:0] mem_tb[16];
    logic [31:0] mdl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc_no);
        end
    endtask

    // One clock: drive at posedge+1, check at negedge, then act as MEM_core.
    task automatic cyc(input logic rn, input logic v, input logic rd, input logic wr,
                       input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] idx,
                       input logic e_stall, input logic e_rd, input logic e_wr,
                       input logic [31:0] e_addr, input logic [31:0] e_wdata);
        @(posedge clk);
        #1;
        cyc_no++;
        rst_n              = rn;
        bus.in_valid       = v;
        bus.in_rd_req      = rd;
        bus.in_wr_req      = wr;
        bus.in_size        = sz;
        bus.in_ld_unsigned = uns;
        bus.in_addr        = a;
        bus.in_st_data     = d;
        bus.in_rd_idx      = idx;
        bus.in_Rd_data     = rd_next;
        @(negedge clk);
        chk("stall",  32'(bus.out_stall), 32'(e_stall));
        chk("mem_rd", 32'(bus.out_MemRd), 32'(e_rd));
        chk("mem_wr", 32'(bus.out_MemWr), 32'(e_wr));
        chk("addr",   bus.out_WrRd_addr, e_addr);
        if (e_wr || !rn) chk("wr_data", bus.out_Wr_data, e_wdata);
        chk("ld_valid", 32'(bus.out_ld_valid), 32'(cyc_no == ld_due));
        if (cyc_no == ld_due) begin
            chk("ld_data", bus.out_ld_data, exp_ld_data);
            chk("ld_idx",  32'(bus.out_ld_rd_idx), 32'(exp_ld_idx));
            last_ld = bus.out_ld_data;
        end
        chk("misalign", 32'(bus.out_misalign), 32'(cyc_no == mis_due));
        rd_next = $urandom();
        if (bus.out_MemWr) begin
            mem_tb[bus.out_WrRd_addr[5:2]] = bus.out_Wr_data;
            last_wd = bus.out_Wr_data;
        end
        if (bus.out_MemRd) rd_next = mem_tb[bus.out_WrRd_addr[5:2]];
    endtask

    task automatic idle();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Transaction-level reference: works in bytes on the model memory.
    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] idx);
        logic        illegal;
        int          nb;
        int          off;
        logic [31:0] wa;
        logic [31:0] w;
        logic [31:0] res;
        string       op;
        illegal = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        illegal = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
`endif
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = (int'(a[1:0]) / nb) * nb;
        wa  = {a[31:2], 2'b00};
        w   = mdl[a[5:2]];
        op  = wr ? ((nb == 1) ? "SB" : (nb == 2) ? "SH" : "SW")
                 : ((nb == 1) ? "LB" : (nb == 2) ? "LH" : "LW");
        n_txn++;
        $display("txn %0d: %s%s addr=%h data=%h idx=%0d%s", n_txn, op,
                 (!wr && uns && nb < 4) ? "U" : "", a, d, idx, illegal ? " (illegal)" : "");
        if (illegal) begin
            cyc(1, 1, rd, wr, sz, uns, a, d, idx, 0, 0, 0, 0, 0);
            mis_due = cyc_no + 1;
        end else if (wr && nb == 4) begin
            cyc(1, 1, rd, wr, sz, uns, a, d, idx, 0, 0, 1, wa, d);
            mdl[a[5:2]] = d;
        end else if (!wr) begin
            cyc(1, 1, rd, wr, sz, uns, a, d, idx, 0, 1, 0, wa, 0);
            res = 0;
            for (int b = 0; b < nb; b++) res[8*b +: 8] = w[8*(off+b) +: 8];
            if (!uns && nb < 4 && res[8*nb-1])
                for (int b = nb; b < 4; b++) res[8*b +: 8] = 8'hFF;
            exp_ld_data = res;
            exp_ld_idx  = idx;
            ld_due      = cyc_no + 2;
            cyc(1, 1, rd, wr, sz, uns, a, d, idx, 1, 0, 0, 0, 0);
        end else begin
            cyc(1, 1, rd, wr, sz, uns, a, d, idx, 0, 1, 0, wa, 0);
            for (int b = 0; b < nb; b++) w[8*(off+b) +: 8] = d[8*b +: 8];
            cyc(1, 1, rd, wr, sz, uns, a, d, idx, 1, 0, 1, wa, w);
            mdl[a[5:2]] = w;
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                                input logic uns, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] e);
        vec_t t;
        t.rd = rd; t.wr = wr; t.sz = sz; t.uns = uns; t.addr = a; t.data = d; t.exp = e;
        return t;
    endfunction

    initial begin
        logic [31:0] v;
        rst_n = 1'b1;
        bus.in_valid = 0; bus.in_rd_req = 0; bus.in_wr_req = 0; bus.in_size = 0;
        bus.in_ld_unsigned = 0; bus.in_addr = 0; bus.in_st_data = 0; bus.in_rd_idx = 0;
        bus.in_Rd_data = 0;
        for (int i = 0; i < 16; i++) begin
            v = $urandom();
            mem_tb[i] = v;
            mdl[i]    = v;
        end
        mem_tb[0] = 32'h8899AABB;
        mdl[0]    = 32'h8899AABB;
        #1 rst_n = 1'b0;

        // Reset: outputs quiet even with a SW request presented.
        cyc(0, 1, 0, 1, 2'd2, 0, 32'h104, 32'h12345678, 5'd7, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 2'd2, 0, 32'h104, 32'h12345678, 5'd7, 0, 0, 0, 0, 0);
        chk("rst_ld_data", bus.out_ld_data, 0);
        chk("rst_ld_idx",  32'(bus.out_ld_rd_idx), 0);
        idle();
        mem_tb[1] = mdl[1];

        // Directed vectors on word 0x100 = 0x8899AABB.
        tbl.push_back(mk(1, 0, 2'd0, 0, 32'h101, 0, 32'hFFFFFFAA));
        tbl.push_back(mk(1, 0, 2'd0, 1, 32'h101, 0, 32'h000000AA));
        tbl.push_back(mk(1, 0, 2'd1, 0, 32'h102, 0, 32'hFFFF8899));
        tbl.push_back(mk(1, 0, 2'd1, 1, 32'h102, 0, 32'h00008899));
        tbl.push_back(mk(1, 0, 2'd2, 0, 32'h100, 0, 32'h8899AABB));
        tbl.push_back(mk(1, 0, 2'd0, 0, 32'h100, 0, 32'hFFFFFFBB));
        tbl.push_back(mk(1, 0, 2'd0, 1, 32'h103, 0, 32'h00000088));
`ifndef LSU_MISALIGN_TRAP_EN
        tbl.push_back(mk(1, 0, 2'd1, 0, 32'h103, 0, 32'hFFFF8899));
`endif
        tbl.push_back(mk(0, 1, 2'd0, 0, 32'h102, 32'h00000011, 32'h8811AABB));
        tbl.push_back(mk(1, 0, 2'd2, 0, 32'h100, 0, 32'h8811AABB));
        tbl.push_back(mk(0, 1, 2'd1, 0, 32'h100, 32'hCAFE1234, 32'h88111234));
        tbl.push_back(mk(1, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF));
        tbl.push_back(mk(1, 0, 2'd0, 0, 32'h103, 0, 32'hFFFFFFDE));
        tbl.push_back(mk(1, 0, 2'd1, 1, 32'h100, 0, 32'h0000BEEF));
        tbl.push_back(mk(1, 0, 2'd1, 0, 32'h100, 0, 32'hFFFFBEEF));
        foreach (tbl[i]) begin
            last_ld = 'x;
            last_wd = 'x;
            issue(tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].data, 5'(i + 1));
            idle();
            chk("vector", tbl[i].wr ? last_wd : last_ld, tbl[i].exp);
        end

        // Back-to-back SW, one per cycle with no stall.
        for (int i = 0; i < 4; i++) issue(0, 1, 2'd2, 0, 32'h110 + 32'(4*i), $urandom(), 0);

        // Reset while in RMW: the merged write must never reach memory.
        mem_tb[0] = 32'h8899AABB;
        mdl[0]    = 32'h8899AABB;
        cyc(1, 1, 0, 1, 2'd0, 0, 32'h102, 32'h11, 5'd2, 0, 1, 0, 32'h100, 0);
        cyc(0, 1, 0, 1, 2'd0, 0, 32'h102, 32'h11, 5'd2, 0, 0, 0, 0, 0);
        chk("rmw_rst_ld_data", bus.out_ld_data, 0);
        chk("rmw_rst_ld_idx",  32'(bus.out_ld_rd_idx), 0);
        idle();
        chk("rmw_rst_mem", mem_tb[0], 32'h8899AABB);
        last_ld = 'x;
        issue(1, 0, 2'd2, 0, 32'h100, 0, 5'd9);
        idle();
        chk("rmw_rst_reload", last_ld, 32'h8899AABB);

        // Reset while in LD_WAIT: no load pulse afterwards.
        cyc(1, 1, 1, 0, 2'd0, 0, 32'h101, 0, 5'd3, 0, 1, 0, 32'h100, 0);
        cyc(0, 1, 1, 0, 2'd0, 0, 32'h101, 0, 5'd3, 0, 0, 0, 0, 0);
        idle();
        idle();

        // Randomised traffic with bubbles and garbage request bits.
        for (int k = 0; k < 250; k++) begin
            int kind;
            if ($urandom_range(0, 4) == 0)
                cyc(1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 0, $urandom(), $urandom(), 0, 0, 0, 0, 0, 0);
            kind = $urandom_range(0, 3);
            issue(kind != 2, kind >= 2, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom(), $urandom(), 5'($urandom_range(0, 31)));
        end
        idle();
        idle();
        idle();
        for (int i = 0; i < 16; i++) chk("final_mem", mem_tb[i], mdl[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_lsu_rmw.md
Name: mem_lsu_rmw

Overview:
Load/store unit sitting directly upstream of MEM_core, between the EX/MEM pipeline register and the data-cache wrapper.
- Turns byte, halfword and word load/store requests into word-aligned MEM_core accesses. Sub-word stores use read-modify-write.
- Sign/zero-extends load results for WB.
- Stalls the pipeline for multi-cycle operations.
- MEM_core has a synchronous read: data for an address presented with MemRd=1 is valid on in_Rd_data in the next cycle.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width (fixed 32; lane logic assumes 4 byte lanes)

Ports:
in_clk  input  1  clock, rising edge
in_rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request present from EX/MEM
in_rd_req  input  1  request is a load
in_wr_req  input  1  request is a store
in_size  input  2  0=byte, 1=half, 2=word, 3=reserved
in_ld_unsigned  input  1  zero-extend load (LBU/LHU)
in_addr  input  32  byte address
in_st_data  input  32  store data (low bits used for sub-word)
in_rd_idx  input  5  load destination register
out_stall  output  1  hold EX/MEM and earlier stages
out_MemWr  output  1  to MEM_core in_MemWr
out_MemRd  output  1  to MEM_core in_MemRd
out_Wr_data  output  32  to MEM_core in_Wr_data
out_WrRd_addr  output  32  to MEM_core in_WrRd_addr, low 2 bits forced 0
in_Rd_data  input  32  from MEM_core out_Rd_data
out_ld_valid  output  1  registered one-cycle load-result pulse to WB
out_ld_data  output  32  extended load result
out_ld_rd_idx  output  5  destination of out_ld_data
out_misalign  output  1  registered one-cycle misalignment pulse

Behaviour:
- Reset (async, in_rst_n=0): state=IDLE; out_ld_valid, out_ld_data, out_ld_rd_idx, out_misalign are 0. Combinational outputs are then 0: out_stall, out_MemWr, out_MemRd, out_Wr_data, out_WrRd_addr.
- Reset mid-operation aborts the operation. A pending RMW write is never issued, and no load pulse is produced.
- Byte lanes are little-endian: addr[1:0]=0 selects bits[7:0]; a halfword at addr[1]=1 selects bits[31:16].
- Alignment check: word needs addr[1:0]=0, half needs addr[0]=0; size=3 is always illegal. Illegal requests make no memory access.
- If in_rd_req and in_wr_req are both 1, the request is treated as a store.
- A request is accepted only in IDLE with in_valid=1. Upstream holds its request while out_stall=1.
- FSM states: IDLE, LD_WAIT, RMW.
  - IDLE, SW aligned: out_MemWr=1, data=in_st_data, same cycle. No stall; stays IDLE.
  - IDLE, load aligned: out_MemRd=1, latch size/unsigned/addr[1:0]/rd_idx → LD_WAIT.
  - IDLE, SB/SH aligned: out_MemRd=1, latch store data, lane and size → RMW.
  - LD_WAIT: out_stall=1. Extract and extend from in_Rd_data and register into out_ld_data. Next cycle out_ld_valid=1 for one cycle → IDLE.
  - RMW: out_stall=1. Merge the latched byte/half into in_Rd_data at the latched lane. Assert out_MemWr=1 with the same word address and merged data → IDLE.
- Latency:
  - Load: accept cycle N, out_ld_valid in cycle N+2, 1 stall cycle.
  - Sub-word store: write in N+1, 1 stall cycle.
  - SW: write in N, 0 stall cycles.
- out_WrRd_addr is driven only while out_MemRd or out_MemWr is 1; otherwise it is 0.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: an illegal request raises out_misalign for one cycle (registered, cycle N+1). No MemRd/MemWr, no load pulse, no stall.
- Undefined: out_misalign is tied 0. Low address bits below the access size are ignored (forced aligned) and the access proceeds. size=3 is treated as word.

Decomposition:
- Shared package mem_lsu_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state encodings, and the lane-select function.
- One natural sub-module: mem_lsu_lane, combinational extract/extend and merge, reused by the LD_WAIT and RMW paths.

Test Plan:
- Memory word 0x100=0x8899AABB; LB 0x101 → MemRd at N, stall at N+1, out_ld_data=0xFFFFFFAA with out_ld_valid at N+2. LBU 0x101 → 0x000000AA.
- LH 0x102 → 0xFFFF8899; LHU 0x102 → 0x00008899.
- SB 0x102, data 0x11 on word 0x8899AABB → MemRd at N, then MemWr addr 0x100 data 0x8811AABB at N+1, stall at N+1 only.
- SW 0x100, data 0xDEADBEEF → MemWr same cycle, no stall. Back-to-back SW accepted every cycle.
- With LSU_MISALIGN_TRAP_EN: LH 0x103 → out_misalign pulse at N+1, no MemRd. Without it: LH 0x103 reads 0x102 → 0xFFFF8899.
- Reset asserted during RMW (cycle N+1) → no MemWr, all outputs 0, memory still 0x8899AABB.
